// File: rtl/ser_par_frame_chk.sv
// ser_par_frame_chk: LSB-first framed serial receiver with selectable parity check and saturating error count
module ser_par_frame_chk #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ser_in,
  input  logic              bit_vld,
  input  logic              par_odd,
  input  logic              clr_cnt,
  output logic              busy,
  output logic              par,
  output logic [DATA_W-1:0] data_out,
  output logic              frame_vld,
  output logic              par_err,
  output logic              frm_err,
  output logic [CNT_W-1:0]  err_cnt
);
  localparam int IDX_W = DATA_W > 1 ? $clog2(DATA_W) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(DATA_W - 1);
  localparam logic [1:0] IDLE = 2'd0, DATA = 2'd1, PARITY = 2'd2, STOP = 2'd3;
  logic [1:0]        r_state;
  logic [IDX_W-1:0]  r_idx;
  logic [DATA_W-1:0] r_sh;
  logic [DATA_W-1:0] r_data;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_mode, r_par, r_busy, r_fvld, r_perr_st, r_perr, r_ferr;
  logic              w_stop, w_inc;
  assign w_stop = bit_vld && r_state == STOP;
  assign w_inc  = w_stop && (r_perr_st || !ser_in) && r_cnt != {CNT_W{1'b1}};
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_idx     <= '0;
      r_sh      <= '0;
      r_data    <= '0;
      r_cnt     <= '0;
      r_mode    <= 1'b0;
      r_par     <= 1'b0;
      r_busy    <= 1'b0;
      r_fvld    <= 1'b0;
      r_perr_st <= 1'b0;
      r_perr    <= 1'b0;
      r_ferr    <= 1'b0;
    end else begin
      r_fvld <= 1'b0;
      r_cnt  <= clr_cnt ? '0 : w_inc ? r_cnt + 1'b1 : r_cnt;
      if (bit_vld) begin
        case (r_state)
          IDLE: if (!ser_in) begin
            r_state <= DATA;
            r_idx   <= '0;
            r_par   <= 1'b0;
            r_mode  <= par_odd;
            r_busy  <= 1'b1;
          end
          DATA: begin
            r_sh[r_idx] <= ser_in;
            r_par       <= r_par ^ ser_in;
            r_idx       <= r_idx + 1'b1;
            r_state     <= r_idx == LAST ? PARITY : DATA;
          end
          PARITY: begin
            r_perr_st <= (r_par ^ ser_in) != r_mode;
            r_state   <= STOP;
          end
          default: begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_fvld  <= 1'b1;
            r_data  <= r_sh;
            r_perr  <= r_perr_st;
            r_ferr  <= !ser_in;
          end
        endcase
      end
    end
  end
  assign busy      = r_busy;
  assign par       = r_par;
  assign data_out  = r_data;
  assign frame_vld = r_fvld;
  assign par_err   = r_perr;
  assign frm_err   = r_ferr;
  assign err_cnt   = r_cnt;
endmodule

// File: tb/tb_ser_par_frame_chk.sv
// tb_ser_par_frame_chk: directed frames with hand-computed results on an 8-bit and a 2-bit counter instance
module tb_ser_par_frame_chk;
  logic clk = 1'b0, rst, ser_in, bit_vld, par_odd, clr_cnt;
  logic busy, par, frame_vld, par_err, frm_err;
  logic [7:0] data_out, err_cnt;
  logic busy2, par2, fvld2, perr2, ferr2;
  logic [7:0] data2;
  logic [1:0] cnt2;
  int n_chk = 0, n_err = 0, n_fv = 0;
  ser_par_frame_chk #(.DATA_W(8), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .ser_in(ser_in), .bit_vld(bit_vld), .par_odd(par_odd), .clr_cnt(clr_cnt),
    .busy(busy), .par(par), .data_out(data_out), .frame_vld(frame_vld), .par_err(par_err),
    .frm_err(frm_err), .err_cnt(err_cnt));
  ser_par_frame_chk #(.DATA_W(8), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .ser_in(ser_in), .bit_vld(bit_vld), .par_odd(par_odd), .clr_cnt(clr_cnt),
    .busy(busy2), .par(par2), .data_out(data2), .frame_vld(fvld2), .par_err(perr2),
    .frm_err(ferr2), .err_cnt(cnt2));
  always #5 clk = ~clk;
  always @(posedge clk) if (frame_vld) n_fv++;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic send_bit(input logic b, input int gap);
    ser_in = b;
    bit_vld = 1'b1;
    @(negedge clk);
    bit_vld = 1'b0;
    repeat (gap) begin
      par_odd = ~par_odd;
      @(negedge clk);
    end
  endtask
  task automatic send_frame(input logic [7:0] d, input logic p, input logic s, input logic mode, input int gap);
    par_odd = mode;
    send_bit(1'b0, gap);
    for (int i = 0; i < 8; i++) send_bit(d[i], gap);
    send_bit(p, gap);
    send_bit(s, gap);
  endtask
  task automatic check_frame(input string tag, input logic [7:0] d, input logic pe, input logic fe,
                             input logic [7:0] cnt, input int fv_before);
    chk({tag, "_data"}, data_out, d);
    chk({tag, "_perr"}, par_err, pe);
    chk({tag, "_ferr"}, frm_err, fe);
    chk({tag, "_cnt"}, err_cnt, cnt);
    chk({tag, "_busy"}, busy, 0);
    repeat (2) @(negedge clk);
    chk({tag, "_fv_count"}, n_fv, fv_before + 1);
    chk({tag, "_fv_low"}, frame_vld, 0);
  endtask
  initial begin
    int fv0;
    rst = 1'b1; ser_in = 1'b1; bit_vld = 1'b0; par_odd = 1'b0; clr_cnt = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_fv", frame_vld, 0);
    chk("rst_data", data_out, 0);
    chk("rst_cnt", err_cnt, 0);
    chk("rst_par", par, 0);
    send_bit(1'b1, 0);
    chk("idle_line_busy", busy, 0);
    fv0 = n_fv;
    send_frame(8'hA5, 1'b1, 1'b1, 1'b1, 0);
    chk("good_pulse", frame_vld, 1);
    chk("good_par", par, 0);
    check_frame("good", 8'hA5, 0, 0, 0, fv0);
    fv0 = n_fv;
    send_frame(8'hA5, 1'b0, 1'b1, 1'b1, 0);
    check_frame("bad_par", 8'hA5, 1, 0, 1, fv0);
    fv0 = n_fv;
    send_frame(8'hA5, 1'b0, 1'b1, 1'b0, 0);
    check_frame("even_ok", 8'hA5, 0, 0, 1, fv0);
    fv0 = n_fv;
    send_frame(8'h3C, 1'b1, 1'b0, 1'b1, 0);
    check_frame("frm_err", 8'h3C, 0, 1, 2, fv0);
    fv0 = n_fv;
    send_frame(8'h3C, 1'b0, 1'b0, 1'b1, 0);
    check_frame("both_err", 8'h3C, 1, 1, 3, fv0);
    chk("both_err_cnt2", cnt2, 3);
    fv0 = n_fv;
    send_frame(8'hA5, 1'b1, 1'b1, 1'b1, 3);
    check_frame("gaps", 8'hA5, 0, 0, 3, fv0);
    fv0 = n_fv;
    par_odd = 1'b1;
    send_bit(1'b0, 0);
    chk("abort_busy_start", busy, 1);
    send_bit(1'b1, 0);
    chk("abort_par_1bit", par, 1);
    send_bit(1'b1, 0);
    send_bit(1'b0, 0);
    send_bit(1'b1, 0);
    chk("abort_par_4bit", par, 1);
    rst = 1'b1;
    ser_in = 1'b1; bit_vld = 1'b1;
    @(negedge clk);
    rst = 1'b0; bit_vld = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_par", par, 0);
    chk("abort_cnt", err_cnt, 0);
    chk("abort_no_fv", n_fv, fv0);
    send_frame(8'h81, 1'b1, 1'b1, 1'b1, 0);
    check_frame("after_abort", 8'h81, 0, 0, 0, fv0);
    for (int k = 0; k < 5; k++) send_frame(8'hA5, 1'b0, 1'b1, 1'b1, 0);
    @(negedge clk);
    chk("sat_cnt8", err_cnt, 5);
    chk("sat_cnt2", cnt2, 3);
    par_odd = 1'b1;
    send_bit(1'b0, 0);
    for (int i = 0; i < 8; i++) send_bit(1'b0, 0);
    send_bit(1'b0, 0);
    clr_cnt = 1'b1;
    send_bit(1'b1, 0);
    clr_cnt = 1'b0;
    chk("clr_pulse", frame_vld, 1);
    chk("clr_perr", par_err, 1);
    chk("clr_cnt8", err_cnt, 0);
    chk("clr_cnt2", cnt2, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
